// File: rtl/instr_encoder.sv
// Instruction-field encoder: turns decoded requests into 32-bit words and streams
// them into an instruction memory through a single stallable output register.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_class,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [19:0] in_imm,
    input  logic        in_last,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [9:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_cnt,
    output logic [9:0]  word_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [2:0] C_OPIMM  = 3'd0;
    localparam logic [2:0] C_OP     = 3'd1;
    localparam logic [2:0] C_J      = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_LOAD   = 3'd4;
    localparam logic [2:0] C_STORE  = 3'd5;

    logic [1:0]  r_state;
    logic [9:0]  r_ptr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [7:0]  r_err_cnt;
    logic [9:0]  r_word_cnt;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_fire;
    logic        w_wr_done;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_word      = '0;
        w_illegal   = 1'b0;
        w_word[6:0] = {4'b0000, in_class};
        case (in_class)
            C_OPIMM: begin
                w_word[11:7]  = in_rd;
                w_word[14:12] = in_funct3;
                w_word[19:15] = in_rs1;
                if (!in_funct3[2]) begin
                    w_word[31:20] = in_imm[11:0];
                end else if (!in_funct3[1]) begin
                    w_word[24:20] = in_imm[4:0];
                    w_word[30]    = in_alt & in_funct3[0];
                end else begin
                    w_illegal = 1'b1;
                end
            end
            C_OP: begin
                w_word[11:7]  = in_rd;
                w_word[14:12] = in_funct3;
                w_word[19:15] = in_rs1;
                w_word[24:20] = in_rs2;
                w_word[30]    = in_alt & in_funct3[2] & in_funct3[1];
                w_illegal     = in_funct3[2] & ~in_funct3[1];
            end
            C_J: begin
                w_word[31]    = in_imm[19];
                w_word[30:21] = in_imm[9:0];
                w_word[20]    = in_imm[10];
                w_word[19:12] = in_imm[18:11];
            end
            C_BRANCH: begin
                w_word[31]    = in_imm[11];
                w_word[30:25] = in_imm[9:4];
                w_word[24:20] = in_rs2;
                w_word[19:15] = in_rs1;
                w_word[14:12] = in_funct3;
                w_word[11:8]  = in_imm[3:0];
                w_word[7]     = in_imm[10];
                w_illegal     = (in_funct3 > 3'd1);
            end
            C_LOAD: begin
                w_word[11:7]  = in_rd;
                w_word[14:12] = in_funct3;
                w_word[19:15] = in_rs1;
            end
            C_STORE: begin
                w_word[14:12] = in_funct3;
                w_word[19:15] = in_rs1;
                w_word[24:20] = in_rs2;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Capture is allowed in the same cycle the pending word drains, giving 1 word/cycle.
    assign in_ready  = !rst && (r_state == S_RUN) && (!r_we || imem_ready);
    assign w_fire    = in_valid && in_ready;
    assign w_wr_done = r_we && imem_ready;

    // NOTE: all state here uses non-blocking assignments; later assignments in the
    // block take priority, which the IDLE start load relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_wr_done) begin
                r_ptr      <= r_ptr + 10'd1;
                r_word_cnt <= r_word_cnt + 10'd1;
            end
            if (w_fire && !w_illegal) begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
            end else if (w_wr_done) begin
                r_we <= 1'b0;
            end
            if (w_fire && w_illegal && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr      <= base_addr;
                        r_err_cnt  <= '0;
                        r_word_cnt <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_fire && in_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_we) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_ptr;
    assign imem_wdata = r_wdata;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DRAIN) && !r_we;
    assign err_cnt    = r_err_cnt;
    assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized program loads, all
// checked every cycle against a transaction-level model of the load protocol.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_class = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_alt = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [19:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic        imem_ready = 1'b1;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;
    logic [9:0]  word_cnt;

    int n_vec = 0;
    int n_miss = 0;
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;

    // Model state: the load is a transaction, pending writes a queue.
    bit          m_loading = 1'b0;
    bit          m_last = 1'b0;
    int          m_ptr = 0;
    int          m_err = 0;
    int          m_wc = 0;
    bit [31:0]   m_q[$];
    logic [31:0] log_d[$];
    logic [9:0]  log_a[$];

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Returns {legal, word}, built by shifting each field into its bit position.
    function automatic bit [32:0] model_encode(input int cls, input int f3, input int alt,
                                               input int rd, input int rs1, input int rs2,
                                               input int imm);
        bit [31:0] w;
        bit legal;
        w = 32'(cls);
        legal = 1'b1;
        case (cls)
            0: begin
                legal = (f3 < 6);
                w |= (rd << 7) | (f3 << 12) | (rs1 << 15);
                if (f3 < 4) w |= (imm & 'hFFF) << 20;
                else        w |= ((imm & 31) << 20) | ((f3 == 5 && alt != 0) ? (1 << 30) : 0);
            end
            1: begin
                legal = !(f3 == 4 || f3 == 5);
                w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                   | ((f3 >= 6 && alt != 0) ? (1 << 30) : 0);
            end
            2: w |= (((imm >> 19) & 1) << 31) | (((imm >> 11) & 'hFF) << 12)
                  | (((imm >> 10) & 1) << 20) | ((imm & 'h3FF) << 21);
            3: begin
                legal = (f3 <= 1);
                w |= (((imm >> 11) & 1) << 31) | (((imm >> 10) & 1) << 7)
                   | (((imm >> 4) & 'h3F) << 25) | ((imm & 'hF) << 8)
                   | (f3 << 12) | (rs1 << 15) | (rs2 << 20);
            end
            4: w |= (rd << 7) | (f3 << 12) | (rs1 << 15);
            5: w |= (f3 << 12) | (rs1 << 15) | (rs2 << 20);
            default: legal = 1'b0;
        endcase
        return {legal, w};
    endfunction

    // Compare process: check outputs, then advance the model to the next edge.
    always @(negedge clk) begin
        bit        exp_rdy, exp_done, was_idle, wr;
        bit [32:0] enc;
        exp_rdy  = !rst && m_loading && !m_last && (m_q.size() == 0 || imem_ready);
        exp_done = m_loading && m_last && (m_q.size() == 0);
        if (mon_en) begin
            check("in_ready", in_ready, exp_rdy);
            check("imem_we", imem_we, m_q.size() != 0);
            check("busy", busy, m_loading);
            check("done", done, exp_done);
            check("err_cnt", err_cnt, m_err);
            check("word_cnt", word_cnt, m_wc);
            if (imem_we && m_q.size() != 0) begin
                check("imem_wdata", imem_wdata, m_q[0]);
                check("imem_addr", imem_addr, m_ptr);
            end
        end
        if (rst) begin
            m_loading = 0; m_last = 0; m_ptr = 0; m_err = 0; m_wc = 0;
            m_q.delete();
        end else begin
            was_idle = !m_loading;
            wr = (m_q.size() != 0) && imem_ready;
            if (wr) begin
                log_d.push_back(imem_wdata);
                log_a.push_back(imem_addr);
                void'(m_q.pop_front());
                m_ptr = (m_ptr + 1) % 1024;
                m_wc  = (m_wc + 1) % 1024;
            end
            if (exp_done) m_loading = 0;
            if (in_valid && exp_rdy) begin
                enc = model_encode(in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm);
                if (enc[32]) m_q.push_back(enc[31:0]);
                else if (m_err < 255) m_err++;
                if (in_last) m_last = 1;
            end
            if (was_idle && start) begin
                m_loading = 1; m_last = 0; m_ptr = base_addr; m_err = 0; m_wc = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) imem_ready = ($urandom_range(0, 3) != 0);
    end

    // Tasks start and end one time unit after a rising edge.
    task automatic start_load(input logic [9:0] base);
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int cls, input int f3, input int alt, input int rd,
                        input int rs1, input int rs2, input int imm, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_class = 3'(cls); in_funct3 = 3'(f3); in_alt = 1'(alt);
        in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 20'(imm);
        in_last = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                timeout("accept");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        bit found;
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            found = done;
        end
        if (!found) timeout("done");
        @(posedge clk); #1;
    endtask

    task automatic rand_req(output int cls, output int f3, output int alt, output int rd,
                            output int rs1, output int rs2, output int imm);
        cls = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
        f3  = $urandom_range(0, 7);
        alt = $urandom_range(0, 1);
        rd  = $urandom_range(0, 31);
        rs1 = $urandom_range(0, 31);
        rs2 = $urandom_range(0, 31);
        imm = $urandom_range(0, 20'hFFFFF);
    endtask

    initial begin
        int c, f, a, d, s1, s2, im, base_log;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ADDI: one-cycle latency and literal encoding.
        start_load(10'h010);
        send(0, 0, 0, 1, 2, 0, 'h005, 1'b1);
        @(negedge clk);
        check("addi_we", imem_we, 1);
        check("addi_addr", imem_addr, 10'h010);
        check("addi_wdata", imem_wdata, 32'h00510080);
        @(posedge clk); #1;
        wait_done();

        // J then BEQ with in_last.
        base_log = log_d.size();
        start_load(10'h020);
        send(2, 6, 1, 5, 9, 11, 'h00001, 1'b0);
        send(3, 0, 0, 7, 3, 4, 'h801, 1'b1);
        wait_done();
        check("jb_count", log_d.size() - base_log, 2);
        if (log_d.size() - base_log == 2) begin
            check("j_wdata", log_d[base_log], 32'h00200002);
            check("beq_wdata", log_d[base_log + 1], 32'h80418103);
        end
        check("jb_word_cnt", word_cnt, 2);

        // Memory stall for three cycles during four back-to-back requests.
        base_log = log_d.size();
        start_load(10'h080);
        imem_ready = 1'b0;
        fork
            begin
                send(4, 2, 0, 1, 2, 3, 0, 1'b0);
                send(5, 2, 0, 1, 2, 3, 0, 1'b0);
                send(1, 7, 1, 4, 5, 6, 0, 1'b0);
                send(0, 5, 1, 8, 9, 10, 'h1F, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                check("stall_we", imem_we, 1);
                repeat (2) @(posedge clk);
                #1 imem_ready = 1'b1;
            end
        join
        wait_done();
        check("stall_count", log_d.size() - base_log, 4);
        check("stall_word_cnt", word_cnt, 4);

        // Address wrap at 0x3FF.
        base_log = log_a.size();
        start_load(10'h3FF);
        send(4, 0, 0, 1, 1, 0, 0, 1'b0);
        send(4, 1, 0, 2, 2, 0, 0, 1'b1);
        wait_done();
        if (log_a.size() - base_log == 2) begin
            check("wrap_addr0", log_a[base_log], 10'h3FF);
            check("wrap_addr1", log_a[base_log + 1], 10'h000);
        end else timeout("wrap_count");

        // Illegal requests: counted, not written, pointer unmoved.
        base_log = log_a.size();
        start_load(10'h100);
        send(6, 0, 0, 1, 1, 1, 0, 1'b0);
        send(1, 4, 0, 1, 1, 1, 0, 1'b0);
        send(0, 0, 0, 1, 1, 0, 3, 1'b1);
        wait_done();
        check("illegal_err_cnt", err_cnt, 2);
        check("illegal_writes", log_a.size() - base_log, 1);
        if (log_a.size() - base_log == 1) check("illegal_addr", log_a[base_log], 10'h100);

        // Reset with a stalled write pending, then reset overriding start.
        start_load(10'h040);
        imem_ready = 1'b0;
        send(0, 0, 0, 3, 3, 0, 7, 1'b0);
        @(negedge clk);
        check("pend_we", imem_we, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_we", imem_we, 0);
        check("rst_mid_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_over_start", busy, 0);
        @(posedge clk); #1;
        imem_ready = 1'b1;

        // Randomized loads with random memory back-pressure and idle gaps.
        rand_rdy = 1'b1;
        for (int l = 0; l < 12; l++) begin
            int len;
            len = $urandom_range(1, 40);
            start_load(10'($urandom));
            for (int k = 0; k < len; k++) begin
                rand_req(c, f, a, d, s1, s2, im);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                send(c, f, a, d, s1, s2, im, k == len - 1);
            end
            wait_done();
        end

        // Error counter saturation.
        start_load(10'h200);
        for (int k = 0; k < 260; k++) send(7, 0, 0, 0, 0, 0, 0, k == 259);
        wait_done();
        check("err_sat", err_cnt, 8'hFF);

        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
